alu_multicycle: RTL



---
 rtl/alu_multicycle.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle ALU: one-cycle simple ops plus optional iterative unsigned mul/div.
// Define ALU_MULDIV_EN to compile in the BUSY state and the shift-add / shift-subtract datapath.
module alu_multicycle #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             sign_flag,
    output logic             carry_flag,
    output logic             overflow_flag
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d, sign_q, sign_d, carry_q, carry_d, ovf_q, ovf_d;

    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] s_res;
    logic             s_carry, s_ovf;

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = SrcB[SHW-1:0];
    assign add_w    = {1'b0, SrcA} + {1'b0, SrcB};
    assign sub_w    = {1'b0, SrcA} - {1'b0, SrcB};

    // Single-cycle ops; anything not listed (including mul/div when compiled out) yields 0.
    always_comb begin
        s_res   = '0;
        s_carry = 1'b0;
        s_ovf   = 1'b0;
        case (ALUControl)
            4'b0000: begin
                s_res   = add_w[WIDTH-1:0];
                s_carry = add_w[WIDTH];
                s_ovf   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (add_w[WIDTH-1] != SrcA[WIDTH-1]);
            end
            4'b0001: s_res = SrcA << shamt;
            4'b0010: begin
                s_res   = sub_w[WIDTH-1:0];
                s_carry = ~sub_w[WIDTH];
                s_ovf   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (sub_w[WIDTH-1] != SrcA[WIDTH-1]);
            end
            4'b0011: s_res = WIDTH'($signed(SrcA) < $signed(SrcB));
            4'b0100: s_res = SrcA ^ SrcB;
            4'b0101: s_res = SrcA >> shamt;
            4'b0110: s_res = SrcA | SrcB;
            4'b0111: s_res = SrcA & SrcB;
            4'b1101: s_res = WIDTH'($signed(SrcA) >>> shamt);
            default: s_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, opd_q, opd_d;
    logic [1:0]       mop_q, mop_d;
    logic [WIDTH:0]   mul_sum, div_rem;
    logic             div_ge, is_md;
    logic [WIDTH-1:0] step_acc, step_lo, md_res;

    assign is_md = (ALUControl[3:2] == 2'b10);

    // One iteration: acc holds product-high / partial remainder, lo holds product-low / quotient.
    // A zero divisor always "subtracts", giving all-ones quotient and the dividend as remainder.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_rem = {acc_q, lo_q[WIDTH-1]};
        div_ge  = (div_rem >= {1'b0, opd_q});
        if (mop_q[1]) begin
            step_acc = div_ge ? WIDTH'(div_rem - {1'b0, opd_q}) : div_rem[WIDTH-1:0];
            step_lo  = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign md_res = mop_q[0] ? step_acc : step_lo;
`endif

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        zero_d      = zero_q;
        sign_d      = sign_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
`ifdef ALU_MULDIV_EN
        cnt_d = cnt_q;
        acc_d = acc_q;
        lo_d  = lo_q;
        opd_d = opd_q;
        mop_d = mop_q;
`endif
        case (state_q)
            S_BUSY: begin
`ifdef ALU_MULDIV_EN
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    res_d       = md_res;
                    zero_d      = (md_res == '0);
                    sign_d      = md_res[WIDTH-1];
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    cnt_d       = '0;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                if ((state_q == S_DONE) && out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
`ifdef ALU_MULDIV_EN
                    if (is_md) begin
                        state_d     = S_BUSY;
                        out_valid_d = 1'b0;
                        cnt_d       = '0;
                        mop_d       = ALUControl[1:0];
                        acc_d       = '0;
                        lo_d        = ALUControl[1] ? SrcA : SrcB;
                        opd_d       = ALUControl[1] ? SrcB : SrcA;
                    end else
`endif
                    begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        res_d       = s_res;
                        zero_d      = (s_res == '0);
                        sign_d      = s_res[WIDTH-1];
                        carry_d     = s_carry;
                        ovf_d       = s_ovf;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef ALU_MULDIV_EN
            cnt_q <= '0;
            acc_q <= '0;
            lo_q  <= '0;
            opd_q <= '0;
            mop_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            sign_q      <= sign_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
`ifdef ALU_MULDIV_EN
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            lo_q  <= lo_d;
            opd_q <= opd_d;
            mop_q <= mop_d;
`endif
        end
    end

    assign out_valid     = out_valid_q;
    assign ALUResult     = res_q;
    assign Zero          = zero_q;
    assign sign_flag     = sign_q;
    assign carry_flag    = carry_q;
    assign overflow_flag = ovf_q;
endmodule
